mux_scan_sequencer: RTL

Sequential driver that sits directly upstream of the 4:1 multiplexer (`structuralMultiplexer` / `behavioralMultiplexer`). It accepts a 4-bit word over a valid/ready handshake and drives it onto the mux data inputs. It then steps `address0`/`address1` through all four selects, waiting a programmable settle time for the gate-level mux to resolve before sampling `out`. Each sampled bit is emitted as a serial stream and self-checked against the latched word, giving an in-system regression of the mux under real clocked sequencing.

---
 rtl/mux_scan_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// Drives a latched 4-bit word onto a 4:1 mux, walks the selects, samples the mux
// output after a settle delay, and self-checks each sample against the latched word.
module mux_scan_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_valid,
   input  logic [3:0] load_data,
   output logic       load_ready,
   output logic       in0,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       address0,
   output logic       address1,
   input  logic       mux_out,
   output logic       bit_valid,
   output logic       bit_data,
   output logic [1:0] bit_index,
   output logic       done,
   output logic       mismatch,
   output logic [3:0] error_count
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] settle_cnt;
   logic [1:0] addr;
   logic [3:0] word;
   logic       expected_bit;

   assign expected_bit = word[addr];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_valid) state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == HOLD_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (addr == 2'd3) ? DONE : SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         addr        <= '0;
         word        <= '0;
         bit_valid   <= 1'b0;
         bit_data    <= 1'b0;
         bit_index   <= '0;
         mismatch    <= 1'b0;
         error_count <= '0;
      end else begin
         state     <= state_nxt;
         bit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  word       <= load_data;
                  addr       <= '0;
                  settle_cnt <= '0;
               end
            end
            SETTLE: settle_cnt <= settle_cnt + 4'd1;
            SAMPLE: begin
               bit_valid <= 1'b1;
               bit_data  <= mux_out;
               bit_index <= addr;
               if (mux_out != expected_bit) begin
                  mismatch <= 1'b1;
                  if (error_count != 4'hF) error_count <= error_count + 4'd1;
               end
               // Address holds at 3 through DONE and into IDLE.
               if (addr != 2'd3) begin
                  addr       <= addr + 2'd1;
                  settle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign load_ready = (state == IDLE);
   assign done       = (state == DONE);
   assign in0        = word[0];
   assign in1        = word[1];
   assign in2        = word[2];
   assign in3        = word[3];
   assign address0   = addr[0];
   assign address1   = addr[1];

endmodule
